// File: rtl/vga_frame_monitor.sv
// vga_frame_monitor: recovers pixel coordinates from sampled VGA sync/rgb, locks to the
// nominal timing, flags sync-period errors and produces a per-frame pixel checksum.
module vga_frame_monitor #(
    parameter int H_DISPLAY = 640,
    parameter int H_FRONT   = 16,
    parameter int H_RETRACE = 96,
    parameter int H_BACK    = 48,
    parameter int V_DISPLAY = 480,
    parameter int V_FRONT   = 10,
    parameter int V_RETRACE = 2,
    parameter int V_BACK    = 33,
    parameter int SYNC_POL  = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pix_en,
    input  logic        hsync,
    input  logic        vsync,
    input  logic [11:0] rgb,
    output logic        locked,
    output logic        pix_valid,
    output logic [9:0]  x,
    output logic [9:0]  y,
    output logic [11:0] pix_rgb,
    output logic        frame_done,
    output logic [15:0] frame_sum,
    output logic [15:0] frame_cnt,
    output logic [9:0]  h_period,
    output logic [9:0]  v_period,
    output logic        sync_err,
    output logic [7:0]  err_count
);
    localparam logic        POL = 1'(SYNC_POL);
    localparam logic [10:0] HT  = 11'(H_DISPLAY + H_FRONT + H_RETRACE + H_BACK);
    localparam logic [9:0]  VT  = 10'(V_DISPLAY + V_FRONT + V_RETRACE + V_BACK);
    localparam logic [9:0]  HS  = 10'(H_RETRACE + H_BACK);
    localparam logic [9:0]  HE  = 10'(H_RETRACE + H_BACK + H_DISPLAY);
    localparam logic [9:0]  VS  = 10'(V_RETRACE + V_BACK);
    localparam logic [9:0]  VE  = 10'(V_RETRACE + V_BACK + V_DISPLAY);

    typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} state_t;

    state_t      state, state_nxt;
    logic        prev_hs, prev_vs, h_ok;
    logic [9:0]  h_cnt, v_line, h_nxt, v_nxt;
    logic [15:0] acc;
    logic        hs_edge, vs_edge, h_good, v_good, meas_ok, err, active;

    assign hs_edge = (hsync == POL) && (prev_hs != POL);
    assign vs_edge = (vsync == POL) && (prev_vs != POL);
    assign h_good  = ({1'b0, h_cnt} + 11'd1) == HT;
    assign v_good  = v_line == VT;
    assign meas_ok = v_good && h_ok && (!hs_edge || h_good);
    assign err     = (state == LOCKED) && ((hs_edge && !h_good) || (vs_edge && !v_good));
    // Coordinates belong to the counter values this sample produces, so the
    // hs_edge sample itself is column 0 of the horizontal count.
    assign h_nxt   = hs_edge ? 10'd0 : (&h_cnt ? h_cnt : h_cnt + 10'd1);
    assign v_nxt   = vs_edge ? 10'd0 : (hs_edge && !(&v_line) ? v_line + 10'd1 : v_line);
    assign active  = (h_nxt >= HS) && (h_nxt < HE) && (v_nxt >= VS) && (v_nxt < VE);
    assign locked  = state == LOCKED;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= SEARCH;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (pix_en)
            case (state)
                SEARCH:  state_nxt = vs_edge ? MEASURE : SEARCH;
                MEASURE: state_nxt = (vs_edge && meas_ok) ? LOCKED : MEASURE;
                default: state_nxt = err ? MEASURE : LOCKED;
            endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev_hs    <= ~POL;
            prev_vs    <= ~POL;
            h_ok       <= 1'b0;
            h_cnt      <= '0;
            v_line     <= '0;
            acc        <= '0;
            pix_valid  <= 1'b0;
            x          <= '0;
            y          <= '0;
            pix_rgb    <= '0;
            frame_done <= 1'b0;
            frame_sum  <= '0;
            frame_cnt  <= '0;
            h_period   <= '0;
            v_period   <= '0;
            sync_err   <= 1'b0;
            err_count  <= '0;
        end else begin
            pix_valid  <= 1'b0;
            frame_done <= 1'b0;
            sync_err   <= 1'b0;
            if (pix_en) begin
                prev_hs <= hsync;
                prev_vs <= vsync;
                h_cnt   <= h_nxt;
                v_line  <= v_nxt;
                if (hs_edge) h_period <= &h_cnt ? h_cnt : h_cnt + 10'd1;
                if (vs_edge) v_period <= v_line;
                // A frame cut short by an error never qualifies for lock.
                if (err) h_ok <= 1'b0;
                else if (vs_edge) h_ok <= 1'b1;
                else if (hs_edge && !h_good) h_ok <= 1'b0;
                if (locked && active) begin
                    pix_valid <= 1'b1;
                    x         <= h_nxt - HS;
                    y         <= v_nxt - VS;
                    pix_rgb   <= rgb;
                end
                if (!locked || err) acc <= '0;
                else if (vs_edge) begin
                    frame_sum  <= acc;
                    acc        <= '0;
                    frame_done <= 1'b1;
                    frame_cnt  <= frame_cnt + 16'd1;
                end else if (active) acc <= acc + {4'd0, rgb};
                if (err) begin
                    sync_err  <= 1'b1;
                    err_count <= &err_count ? err_count : err_count + 8'd1;
                end
            end
        end
    end
endmodule

// File: tb/tb_vga_frame_monitor.sv
// tb_vga_frame_monitor: directed test of vga_frame_monitor on a scaled-down raster
// (15 px x 8 lines, 8x4 active) so several whole frames fit in a short run.
module tb_vga_frame_monitor;
    localparam int HD = 8, HF = 2, HR = 3, HB = 2, HT = 15;
    localparam int VD = 4, VF = 1, VR = 1, VB = 2;

    logic        clk = 1'b0, reset = 1'b0, pix_en = 1'b0, hsync = 1'b1, vsync = 1'b1;
    logic [11:0] rgb = '0;
    logic        locked, pix_valid, frame_done, sync_err;
    logic [9:0]  x, y, h_period, v_period;
    logic [11:0] pix_rgb;
    logic [15:0] frame_sum, frame_cnt;
    logic [7:0]  err_count;

    int checks = 0, errors = 0;
    int hc = 0, vc = 0, mode = 0, npix = 0;
    bit stretch = 1'b0, chk_pix = 1'b0;

    vga_frame_monitor #(
        .H_DISPLAY(HD), .H_FRONT(HF), .H_RETRACE(HR), .H_BACK(HB),
        .V_DISPLAY(VD), .V_FRONT(VF), .V_RETRACE(VR), .V_BACK(VB), .SYNC_POL(0)
    ) dut (
        .clk(clk), .reset(reset), .pix_en(pix_en), .hsync(hsync), .vsync(vsync), .rgb(rgb),
        .locked(locked), .pix_valid(pix_valid), .x(x), .y(y), .pix_rgb(pix_rgb),
        .frame_done(frame_done), .frame_sum(frame_sum), .frame_cnt(frame_cnt),
        .h_period(h_period), .v_period(v_period), .sync_err(sync_err), .err_count(err_count)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [11:0] gen_rgb(input int h, input int v);
        return mode != 0 ? 12'(h + 16 * v) : 12'd1;
    endfunction

    task automatic drive_pix(input logic hs, input logic vs, input logic [11:0] c);
        repeat (3) @(posedge clk);
        #1;
        hsync  = hs;
        vsync  = vs;
        rgb    = c;
        pix_en = 1'b1;
        @(posedge clk);
        #1;
        pix_en = 1'b0;
    endtask

    // Retrace follows front porch, so hs_edge lands at hc=HD+HF and vs_edge at vc=VD+VF.
    task automatic pix();
        int h0 = hc, v0 = vc;
        drive_pix(!(hc >= HD + HF && hc < HD + HF + HR), !(vc >= VD + VF && vc < VD + VF + VR),
                  gen_rgb(hc, vc));
        if (hc == (stretch ? HT : HT - 1)) begin
            hc = 0;
            stretch = 1'b0;
            vc = (vc == 7) ? 0 : vc + 1;
        end else hc++;
        if (chk_pix) begin
            chk("pix_valid", pix_valid, (h0 < HD && v0 < VD));
            if (pix_valid) begin
                npix++;
                chk("x", x, h0);
                chk("y", y, v0);
                chk("pix_rgb", pix_rgb, gen_rgb(h0, v0));
            end
        end
    endtask

    task automatic run_to(input int v, input int h);
        int n = 0;
        while (!(vc == v && hc == h) && n < 2000) begin
            pix();
            n++;
        end
        chk("run_to_bound", n < 2000, 1);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_locked", locked, 0);
        chk("rst_pix_valid", pix_valid, 0);
        chk("rst_frame_cnt", frame_cnt, 0);
        chk("rst_h_period", h_period, 0);
        chk("rst_err_count", err_count, 0);
        @(negedge clk);
        reset = 1'b1;

        // Lock acquisition and first checksum frame with rgb=1
        run_to(5, 0);
        pix();
        chk("lock_vs1", locked, 0);
        run_to(5, 0);
        chk("lock_pre_vs2", locked, 0);
        pix();
        chk("lock_vs2", locked, 1);
        chk_pix = 1'b1;
        npix = 0;
        run_to(5, 0);
        chk("fd_before", frame_done, 0);
        pix();
        chk("fd_pulse", frame_done, 1);
        chk("frame_sum1", frame_sum, 32);
        chk("frame_cnt1", frame_cnt, 1);
        chk("h_period", h_period, 15);
        chk("v_period", v_period, 8);
        chk("err_count0", err_count, 0);
        chk("npix1", npix, 32);
        @(posedge clk);
        #1;
        chk("fd_drop", frame_done, 0);

        // Coordinate-dependent colour
        mode = 1;
        npix = 0;
        run_to(5, 0);
        pix();
        chk("npix2", npix, 32);
        chk("frame_sum2", frame_sum, 16'h0370);
        chk("frame_cnt2", frame_cnt, 2);

        // One line stretched by a pixel
        chk_pix = 1'b0;
        mode = 0;
        run_to(7, 0);
        stretch = 1'b1;
        run_to(0, 10);
        pix();
        chk("str_sync_err", sync_err, 1);
        chk("str_err_count", err_count, 1);
        chk("str_locked", locked, 0);
        chk("str_h_period", h_period, 16);
        @(posedge clk);
        #1;
        chk("str_err_drop", sync_err, 0);
        run_to(5, 0);
        pix();
        chk("str_fd_supp", frame_done, 0);
        chk("str_locked2", locked, 0);
        chk("str_frame_cnt", frame_cnt, 2);
        chk("str_sum_held", frame_sum, 16'h0370);
        run_to(5, 0);
        pix();
        chk("str_relock", locked, 1);

        // Asynchronous reset mid-frame
        repeat (30) pix();
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("ar_locked", locked, 0);
        chk("ar_frame_cnt", frame_cnt, 0);
        chk("ar_frame_sum", frame_sum, 0);
        chk("ar_err_count", err_count, 0);
        chk("ar_h_period", h_period, 0);
        chk("ar_v_period", v_period, 0);
        chk("ar_x", x, 0);
        @(negedge clk);
        reset = 1'b1;

        // Sync activity with pix_en held low
        for (int i = 0; i < 10000; i++) begin
            @(posedge clk);
            #1;
            hsync = i[3];
            vsync = i[6];
            rgb   = 12'(i);
        end
        chk("pe_locked", locked, 0);
        chk("pe_h_period", h_period, 0);
        chk("pe_v_period", v_period, 0);
        chk("pe_frame_cnt", frame_cnt, 0);
        chk("pe_pix_valid", pix_valid, 0);
        chk("pe_pix_rgb", pix_rgb, 0);

        hc = 0;
        vc = 0;
        run_to(5, 0);
        pix();
        chk("rl_vs1", locked, 0);
        run_to(5, 0);
        pix();
        chk("rl_vs2", locked, 1);

        // Long hsync absence saturates the period measurement
        repeat (2000) drive_pix(1'b1, 1'b1, 12'd0);
        chk("hold_locked", locked, 1);
        drive_pix(1'b0, 1'b1, 12'd0);
        chk("hold_sync_err", sync_err, 1);
        chk("hold_h_period", h_period, 1023);
        chk("hold_err_count", err_count, 1);
        chk("hold_locked0", locked, 0);
        repeat (20) drive_pix(1'b1, 1'b1, 12'd0);
        chk("hold_stay_meas", locked, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
